io_port_peer: RTL and testbench

IO_PORT_PEER -- requirements
Module: io_port_peer

---
 rtl/io_port_peer_if.sv | 38 +++
 rtl/io_port_peer.sv | 171 +++++++++++++++++
 tb/tb_io_port_peer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_peer_if.sv
// Bundle of the processor four-phase links and the host FIFO ports of io_port_peer.
// The master modport is the environment side; the slave modport is the peer block itself.
interface io_port_peer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] proc_in;
    logic             proc_inDataReady;
    logic             proc_inACK;
    logic [WIDTH-1:0] proc_out;
    logic             proc_outDataReady;
    logic             proc_outACK;
    logic             host_wr_en;
    logic [WIDTH-1:0] host_wr_data;
    logic             host_full;
    logic             host_rd_en;
    logic [WIDTH-1:0] host_rd_data;
    logic             host_empty;
    logic [LW-1:0]    tx_level;
    logic [LW-1:0]    rx_level;
    logic             wr_err;

    modport master (
        input  proc_in, proc_inDataReady, proc_outACK, host_full, host_rd_data,
               host_empty, tx_level, rx_level, wr_err,
        output proc_inACK, proc_out, proc_outDataReady, host_wr_en, host_wr_data,
               host_rd_en
    );

    modport slave (
        output proc_in, proc_inDataReady, proc_outACK, host_full, host_rd_data,
               host_empty, tx_level, rx_level, wr_err,
        input  proc_inACK, proc_out, proc_outDataReady, host_wr_en, host_wr_data,
               host_rd_en
    );
endinterface

// File: rtl/io_port_peer.sv
// Host-to-processor bridge: a TX FIFO drained over a four-phase link into the processor's
// in port, and an RX FIFO filled from the processor's out port, with registered status.
module io_port_peer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    io_port_peer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_C = LW'(DEPTH);
    localparam logic [LW-1:0] ZERO_C = LW'(0);
    localparam logic [LW-1:0] ONE_C  = LW'(1);
    localparam logic [PW-1:0] STEP_C = PW'(1);

    typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_REL = 2'd2} tx_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;

    logic [WIDTH-1:0] tx_mem_r [DEPTH];
    logic [WIDTH-1:0] rx_mem_r [DEPTH];
    logic [PW-1:0]    tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic [LW-1:0]    tx_count_r, rx_count_r;
    tx_state_t        tx_state_r, tx_state_nxt_s;
    rx_state_t        rx_state_r, rx_state_nxt_s;
    logic [WIDTH-1:0] proc_in_r, proc_in_nxt_s;
    logic             in_rdy_r, in_rdy_nxt_s;
    logic             out_ack_r, out_ack_nxt_s;
    logic             wr_err_r;
    logic             tx_full_s, rx_full_s, rx_empty_s;
    logic             tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

    assign tx_full_s  = (tx_count_r == FULL_C);
    assign rx_full_s  = (rx_count_r == FULL_C);
    assign rx_empty_s = (rx_count_r == ZERO_C);
    // A write while full is dropped even if the TX FSM pops in the same cycle.
    assign tx_push_s  = bus.host_wr_en & ~tx_full_s;
    assign rx_pop_s   = bus.host_rd_en & ~rx_empty_s;

    // TX link next state: load head, wait for ACK, then wait for ACK release.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        proc_in_nxt_s  = proc_in_r;
        in_rdy_nxt_s   = in_rdy_r;
        tx_pop_s       = 1'b0;
        case (tx_state_r)
            T_IDLE: begin
                if ((tx_count_r != ZERO_C) && !bus.proc_inACK) begin
                    proc_in_nxt_s  = tx_mem_r[tx_rptr_r];
                    in_rdy_nxt_s   = 1'b1;
                    tx_state_nxt_s = T_REQ;
                end else begin
                    tx_state_nxt_s = T_IDLE;
                end
            end
            T_REQ: begin
                if (bus.proc_inACK) begin
                    tx_pop_s       = 1'b1;
                    in_rdy_nxt_s   = 1'b0;
                    tx_state_nxt_s = T_REL;
                end else begin
                    tx_state_nxt_s = T_REQ;
                end
            end
            T_REL: begin
                if (!bus.proc_inACK) begin
                    tx_state_nxt_s = T_IDLE;
                end else begin
                    tx_state_nxt_s = T_REL;
                end
            end
            default: begin
                tx_state_nxt_s = T_IDLE;
                in_rdy_nxt_s   = 1'b0;
            end
        endcase
    end

    // RX link next state: capture one byte per handshake, backpressure while full.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        out_ack_nxt_s  = out_ack_r;
        rx_push_s      = 1'b0;
        case (rx_state_r)
            R_IDLE: begin
                if (bus.proc_outDataReady && !rx_full_s) begin
                    rx_push_s      = 1'b1;
                    out_ack_nxt_s  = 1'b1;
                    rx_state_nxt_s = R_ACK;
                end else begin
                    rx_state_nxt_s = R_IDLE;
                end
            end
            R_ACK: begin
                if (!bus.proc_outDataReady) begin
                    out_ack_nxt_s  = 1'b0;
                    rx_state_nxt_s = R_IDLE;
                end else begin
                    rx_state_nxt_s = R_ACK;
                end
            end
            default: begin
                rx_state_nxt_s = R_IDLE;
                out_ack_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state and registered link outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= T_IDLE;
            rx_state_r <= R_IDLE;
            proc_in_r  <= {WIDTH{1'b0}};
            in_rdy_r   <= 1'b0;
            out_ack_r  <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            rx_state_r <= rx_state_nxt_s;
            proc_in_r  <= proc_in_nxt_s;
            in_rdy_r   <= in_rdy_nxt_s;
            out_ack_r  <= out_ack_nxt_s;
            wr_err_r   <= wr_err_r | (bus.host_wr_en & tx_full_s);
        end
    end

    // FIFO pointers and occupancy counts; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_r  <= {PW{1'b0}};
            tx_rptr_r  <= {PW{1'b0}};
            tx_count_r <= ZERO_C;
            rx_wptr_r  <= {PW{1'b0}};
            rx_rptr_r  <= {PW{1'b0}};
            rx_count_r <= ZERO_C;
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + STEP_C;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + STEP_C;
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + STEP_C;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + STEP_C;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + ONE_C;
                2'b01:   tx_count_r <= tx_count_r - ONE_C;
                default: tx_count_r <= tx_count_r;
            endcase
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + ONE_C;
                2'b01:   rx_count_r <= rx_count_r - ONE_C;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // FIFO storage; contents are only observed through valid counts, so no reset.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r] <= bus.host_wr_data;
        if (rx_push_s) rx_mem_r[rx_wptr_r] <= bus.proc_out;
    end

    assign bus.proc_in          = proc_in_r;
    assign bus.proc_inDataReady = in_rdy_r;
    assign bus.proc_outACK      = out_ack_r;
    assign bus.wr_err           = wr_err_r;
    assign bus.host_full        = tx_full_s;
    assign bus.host_empty       = rx_empty_s;
    assign bus.tx_level         = tx_count_r;
    assign bus.rx_level         = rx_count_r;
    assign bus.host_rd_data     = rx_mem_r[rx_rptr_r];
endmodule

// File: tb/tb_io_port_peer.sv
// Directed bench for io_port_peer: queue-based protocol model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_io_port_peer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    io_port_peer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    io_port_peer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    bit auto_ack = 1'b0;
    bit hold_ack = 1'b0;
    bit arm_hold = 1'b0;
    logic [WIDTH-1:0] got_in [$];

    // Reference model: FIFO contents as queues plus the visible handshake levels.
    logic [WIDTH-1:0] m_txq [$];
    logic [WIDTH-1:0] m_rxq [$];
    logic [WIDTH-1:0] m_in;
    bit m_req, m_rel, m_ack, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        int tx_n, rx_n;
        bit cap;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_txq.delete(); m_rxq.delete();
                m_in = '0; m_req = 0; m_rel = 0; m_ack = 0; m_err = 0;
            end else begin
                tx_n = m_txq.size();
                rx_n = m_rxq.size();
                if (m_req) begin
                    if (bus.proc_inACK) begin
                        void'(m_txq.pop_front());
                        m_req = 0; m_rel = 1;
                    end
                end else if (m_rel) begin
                    if (!bus.proc_inACK) m_rel = 0;
                end else if (tx_n > 0 && !bus.proc_inACK) begin
                    m_in = m_txq[0]; m_req = 1;
                end
                if (bus.host_wr_en) begin
                    if (tx_n == DEPTH) m_err = 1;
                    else m_txq.push_back(bus.host_wr_data);
                end
                cap = !m_ack && bus.proc_outDataReady && (rx_n < DEPTH);
                if (bus.host_rd_en && rx_n > 0) void'(m_rxq.pop_front());
                if (cap) begin
                    m_rxq.push_back(bus.proc_out);
                    m_ack = 1;
                end else if (m_ack && !bus.proc_outDataReady) begin
                    m_ack = 0;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("cyc_proc_in", bus.proc_in, m_in);
                chk("cyc_in_ready", bus.proc_inDataReady, m_req);
                chk("cyc_out_ack", bus.proc_outACK, m_ack);
                chk("cyc_wr_err", bus.wr_err, m_err);
                chk("cyc_tx_level", bus.tx_level, m_txq.size());
                chk("cyc_rx_level", bus.rx_level, m_rxq.size());
                chk("cyc_full", bus.host_full, m_txq.size() == DEPTH);
                chk("cyc_empty", bus.host_empty, m_rxq.size() == 0);
                if (m_rxq.size() > 0) chk("cyc_rd_data", bus.host_rd_data, m_rxq[0]);
            end
        end
    end

    // Processor side of the TX link: acknowledges a request after two cycles.
    initial begin : responder
        int cnt = 0;
        bus.proc_inACK = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.proc_inACK = 1'b0;
                cnt = 0;
            end else if (hold_ack) begin
                cnt = 0;
            end else if (auto_ack) begin
                if (bus.proc_inDataReady && !bus.proc_inACK) begin
                    cnt++;
                    if (cnt >= 2) begin
                        bus.proc_inACK = 1'b1;
                        got_in.push_back(bus.proc_in);
                        cnt = 0;
                        if (arm_hold) begin hold_ack = 1'b1; arm_hold = 1'b0; end
                    end
                end else if (!bus.proc_inDataReady && bus.proc_inACK) begin
                    bus.proc_inACK = 1'b0;
                end
            end
        end
    end

    task automatic host_push(input logic [WIDTH-1:0] b);
        bus.host_wr_en = 1'b1; bus.host_wr_data = b;
        @(negedge clk);
        bus.host_wr_en = 1'b0;
    endtask

    task automatic host_pop(input int n);
        bus.host_rd_en = 1'b1;
        repeat (n) @(negedge clk);
        bus.host_rd_en = 1'b0;
    endtask

    task automatic wait_out_ack(input string tag, input bit level);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.proc_outACK == level) ok = 1;
        end
        if (!ok) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [WIDTH-1:0] b);
        bus.proc_out = b; bus.proc_outDataReady = 1'b1;
        wait_out_ack("send_ack_rise", 1'b1);
        bus.proc_outDataReady = 1'b0;
        wait_out_ack("send_ack_fall", 1'b0);
    endtask

    task automatic wait_tx_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_level == '0 && !bus.proc_inDataReady && !bus.proc_inACK) ok = 1;
        end
        if (!ok) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        bus.proc_out = '0; bus.proc_outDataReady = 1'b0;
        bus.host_wr_en = 1'b0; bus.host_wr_data = '0; bus.host_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.proc_inDataReady, 1'b0);
        chk("rst_proc_in", bus.proc_in, 8'h00);
        chk("rst_out_ack", bus.proc_outACK, 1'b0);
        chk("rst_empty", bus.host_empty, 1'b1);
        chk("rst_full", bus.host_full, 1'b0);
        chk("rst_levels", {bus.tx_level, bus.rx_level}, 0);
        reset = 1'b1; cmp_en = 1'b1;

        // Three bytes host -> processor, in order.
        auto_ack = 1'b1;
        host_push(8'h11); host_push(8'h22); host_push(8'h33);
        wait_tx_idle("tx3_timeout");
        chk("tx3_count", got_in.size(), 3);
        if (got_in.size() == 3) begin
            chk("tx3_b0", got_in[0], 8'h11);
            chk("tx3_b1", got_in[1], 8'h22);
            chk("tx3_b2", got_in[2], 8'h33);
        end
        chk("tx3_level", bus.tx_level, 0);
        got_in.delete();

        // Two bytes processor -> host, first-word-fall-through.
        send_byte(8'hA5); send_byte(8'h5A);
        chk("rx2_level", bus.rx_level, 2);
        chk("rx2_head0", bus.host_rd_data, 8'hA5);
        host_pop(1);
        chk("rx2_head1", bus.host_rd_data, 8'h5A);
        host_pop(1);
        host_pop(2);
        chk("rx_empty_pop_level", bus.rx_level, 0);
        chk("rx_empty_pop_flag", bus.host_empty, 1'b1);

        // RX full backpressure.
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("rxf_level", bus.rx_level, 4);
        bus.proc_out = 8'h77; bus.proc_outDataReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rxf_ack_held", bus.proc_outACK, 1'b0);
        end
        host_pop(1);
        wait_out_ack("rxf_ack_rise", 1'b1);
        bus.proc_outDataReady = 1'b0;
        wait_out_ack("rxf_ack_fall", 1'b0);
        chk("rxf_level4", bus.rx_level, 4);
        host_pop(3);
        chk("rxf_entry4", bus.host_rd_data, 8'h77);
        host_pop(1);

        // TX full: overflow write is dropped and flagged.
        auto_ack = 1'b0;
        host_push(8'hD1); host_push(8'hD2); host_push(8'hD3); host_push(8'hD4);
        host_push(8'h99);
        chk("txf_err", bus.wr_err, 1'b1);
        chk("txf_level", bus.tx_level, 4);
        auto_ack = 1'b1;
        wait_tx_idle("txf_timeout");
        chk("txf_count", got_in.size(), 4);
        if (got_in.size() == 4) begin
            chk("txf_b0", got_in[0], 8'hD1);
            chk("txf_b3", got_in[3], 8'hD4);
        end
        got_in.delete();

        // ACK held high after a transfer blocks the next request.
        arm_hold = 1'b1;
        host_push(8'hA1); host_push(8'hB2);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (hold_ack) ok = 1;
        end
        if (!ok) chk("hold_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_no_req", bus.proc_inDataReady, 1'b0);
        end
        chk("hold_level", bus.tx_level, 1);
        hold_ack = 1'b0;
        wait_tx_idle("hold_timeout2");
        chk("hold_count", got_in.size(), 2);
        if (got_in.size() == 2) chk("hold_b1", got_in[1], 8'hB2);

        // Reset in the middle of a request.
        auto_ack = 1'b0;
        host_push(8'hC3);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.proc_inDataReady) ok = 1;
        end
        if (!ok) chk("mid_req_timeout", 32'd0, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", bus.proc_inDataReady, 1'b0);
        chk("mid_rst_tx_level", bus.tx_level, 0);
        chk("mid_rst_rx_level", bus.rx_level, 0);
        chk("mid_rst_wr_err", bus.wr_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", bus.proc_inDataReady, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
